// File: rtl/uart_event_framer.sv
// Round-robin event framer: captures per-channel event payloads and emits
// SYNC/header/payload[/checksum] byte frames into a UART TX FIFO. Checksum byte gated by UART_FRAMER_CSUM_EN.
module uart_event_framer #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned PAYLOAD_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_CH-1:0]                 ev_req,
    input  logic [N_CH*PAYLOAD_BYTES*8-1:0] ev_payload,
    output logic [N_CH-1:0]                 ev_ack,
    output logic [N_CH-1:0]                 overrun,
    input  logic                            ovr_clr,
    input  logic                            tx_full,
    output logic                            wr_uart,
    output logic [7:0]                      w_data,
    output logic                            busy
);

    localparam int unsigned PW = PAYLOAD_BYTES * 8;

    typedef enum logic [2:0] {StIdle, StSync, StHdr, StPay, StCsum} state_e;

    state_e          state_q, state_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overrun_q, overrun_d;
    logic [N_CH-1:0] ev_ack_q;
    logic [N_CH-1:0] new_ovr;
    logic [N_CH-1:0] grant_oh;
    logic [PW-1:0]   hold_q [N_CH];
    logic [PW-1:0]   frame_q, frame_d;
    logic [PW-1:0]   grant_hold;
    logic [3:0]      seq_q;
    logic [3:0]      last_grant_q;
    logic [3:0]      grant_idx;
    logic            grant_found;
    logic            grant_en;
    logic [7:0]      hdr_q;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic            wr_uart_q, wr_uart_d;
    logic [7:0]      w_data_q, w_data_d;
    logic            can_emit;
    logic            last_pay;
`ifdef UART_FRAMER_CSUM_EN
    logic [7:0]      csum_q;
    logic [7:0]      grant_csum;
`endif

    // Round-robin search starting at the channel after the last grant.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = 4'd0;
        for (int i = 1; i <= int'(N_CH); i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= int'(N_CH)) begin
                idx = idx - int'(N_CH);
            end
            for (int k = 0; k < int'(N_CH); k++) begin
                if (!grant_found && idx == k && pending_q[k]) begin
                    grant_found = 1'b1;
                    grant_idx   = 4'(k);
                end
            end
        end
    end

    always_comb begin
        grant_hold = '0;
        grant_oh   = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (grant_idx == 4'(k)) begin
                grant_hold = hold_q[k];
            end
            grant_oh[k] = grant_en && (grant_idx == 4'(k));
        end
    end

`ifdef UART_FRAMER_CSUM_EN
    always_comb begin
        grant_csum = {seq_q, grant_idx};
        for (int b = 0; b < int'(PAYLOAD_BYTES); b++) begin
            grant_csum = grant_csum ^ grant_hold[b*8 +: 8];
        end
    end
`endif

    // A request colliding with its own grant re-arms pending without an overrun.
    assign new_ovr   = ev_req & pending_q & ~grant_oh;
    assign pending_d = (pending_q & ~grant_oh) | ev_req;
    assign overrun_d = (overrun_q & ~{N_CH{ovr_clr}}) | new_ovr;

    // The previous-cycle write doubles as the gap flag.
    assign can_emit = !tx_full && !wr_uart_q;
    assign last_pay = (byte_cnt_q == 3'(PAYLOAD_BYTES - 1));

    always_comb begin
        state_d    = state_q;
        wr_uart_d  = 1'b0;
        w_data_d   = w_data_q;
        grant_en   = 1'b0;
        frame_d    = frame_q;
        byte_cnt_d = byte_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found && !wr_uart_q) begin
                    grant_en = 1'b1;
                    frame_d  = grant_hold;
                    state_d  = StSync;
                end
            end
            StSync: begin
                if (can_emit) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = SYNC_BYTE;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                if (can_emit) begin
                    wr_uart_d  = 1'b1;
                    w_data_d   = hdr_q;
                    byte_cnt_d = 3'd0;
                    state_d    = StPay;
                end
            end
            StPay: begin
                if (can_emit) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = frame_q[PW-1 -: 8];
                    frame_d   = frame_q << 8;
                    if (last_pay) begin
`ifdef UART_FRAMER_CSUM_EN
                        state_d = StCsum;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_FRAMER_CSUM_EN
            StCsum: begin
                if (can_emit) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = csum_q;
                    state_d   = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            overrun_q    <= '0;
            ev_ack_q     <= '0;
            frame_q      <= '0;
            seq_q        <= 4'd0;
            last_grant_q <= 4'(N_CH - 1);
            hdr_q        <= 8'h00;
            byte_cnt_q   <= 3'd0;
            wr_uart_q    <= 1'b0;
            w_data_q     <= 8'h00;
            for (int k = 0; k < int'(N_CH); k++) begin
                hold_q[k] <= '0;
            end
`ifdef UART_FRAMER_CSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            ev_ack_q   <= grant_oh;
            frame_q    <= frame_d;
            byte_cnt_q <= byte_cnt_d;
            wr_uart_q  <= wr_uart_d;
            w_data_q   <= w_data_d;
            for (int k = 0; k < int'(N_CH); k++) begin
                if (ev_req[k]) begin
                    hold_q[k] <= ev_payload[k*PW +: PW];
                end
            end
            if (grant_en) begin
                seq_q        <= seq_q + 4'd1;
                last_grant_q <= grant_idx;
                hdr_q        <= {seq_q, grant_idx};
`ifdef UART_FRAMER_CSUM_EN
                csum_q       <= grant_csum;
`endif
            end
        end
    end

    assign ev_ack  = ev_ack_q;
    assign overrun = overrun_q;
    assign wr_uart = wr_uart_q;
    assign w_data  = w_data_q;
    assign busy    = (state_q != StIdle);

endmodule
